// File: rtl/mul_repeated_add.sv
// Unsigned multiplier by repeated addition: A and B arrive on a shared bus after start,
// B counts down while A accumulates into P. Optional MUL_SWAP_EN swaps A/B so the count uses min(A,B).
module mul_repeated_add #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   data_in,
   output logic [2*WIDTH-1:0] product,
   output logic               done,
   output logic               busy
);

   // state  | meaning
   // IDLE   | waiting for start, done=0
   // LOAD_A | capture A from data_in
   // LOAD_B | capture B from data_in, clear P
   // ADD    | P += A while B != 0, B counts down
   // DONE   | result held; done rises one edge after entry, leave once start seen low

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_ADD    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic               b_eqz;
   logic [2*WIDTH-1:0] a_ext;

   assign b_eqz = (b_reg == '0);
   assign a_ext = {{WIDTH{1'b0}}, a_reg};

`ifdef MUL_SWAP_EN
   logic first_add;
   logic swap_req;
   assign swap_req = first_add && (b_reg > a_reg);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         product <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
`ifdef MUL_SWAP_EN
         first_add <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  state <= S_LOAD_A;
                  busy  <= 1'b1;
               end
            end
            S_LOAD_A: begin
               a_reg <= data_in;
               state <= S_LOAD_B;
            end
            S_LOAD_B: begin
               b_reg   <= data_in;
               product <= '0;
               state   <= S_ADD;
`ifdef MUL_SWAP_EN
               first_add <= 1'b1;
`endif
            end
            S_ADD: begin
`ifdef MUL_SWAP_EN
               first_add <= 1'b0;
               if (swap_req) begin
                  // spend one cycle so the counter holds the smaller operand
                  a_reg <= b_reg;
                  b_reg <= a_reg;
               end else
`endif
               if (!b_eqz) begin
                  product <= product + a_ext;
                  b_reg   <= b_reg - 1'b1;
               end else begin
                  state <= S_DONE;
                  busy  <= 1'b0;
               end
            end
            S_DONE: begin
               busy <= 1'b0;
               if (!done) begin
                  done <= 1'b1;
               end else if (!start) begin
                  done  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_repeated_add.sv
// Directed bench for mul_repeated_add: product, done latency, busy and start handshake.
// Build with +define+MUL_SWAP_EN to check the swap latency.
module tb_mul_repeated_add;

   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [WIDTH-1:0]   data_in = '0;
   logic [2*WIDTH-1:0] product;
   logic               done;
   logic               busy;

   int n_chk  = 0;
   int n_pass = 0;

   mul_repeated_add #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .data_in (data_in),
      .product (product),
      .done    (done),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int exp_lat(input int a, input int b);
`ifdef MUL_SWAP_EN
      if (b > a) return a + 5;
`endif
      return b + 4;
   endfunction

   // edges are counted from the edge that sampled start (edge 0)
   task automatic run_op(input string tag, input int a, input int b, input bit hold);
      int edges;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = hold;
      data_in = WIDTH'(a);
      @(posedge clk);
      #1;
      data_in = WIDTH'(b);
      edges = 1;
      chk({tag, "_busy_run"}, 32'(busy), 32'd1);
      while (done !== 1'b1 && edges < 600) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges > 2) data_in = WIDTH'($urandom);
      end
      chk({tag, "_product"}, 32'(product), 32'(a * b));
      chk({tag, "_latency"}, 32'(edges), 32'(exp_lat(a, b)));
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      if (hold) begin
         repeat (3) @(posedge clk);
         #1;
         chk({tag, "_done_held"}, 32'(done), 32'd1);
         chk({tag, "_product_held"}, 32'(product), 32'(a * b));
         start = 1'b0;
      end
      @(posedge clk);
      #1;
      chk({tag, "_done_clear"}, 32'(done), 32'd0);
      data_in = '0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_product", 32'(product), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      run_op("basic", 255, 200, 1'b0);
      run_op("b_zero", 7, 0, 1'b0);
      run_op("a_zero", 0, 9, 1'b0);
      run_op("max", 255, 255, 1'b0);
      run_op("hold", 12, 13, 1'b1);
      run_op("swap", 3, 250, 1'b0);
      run_op("noswap", 250, 3, 1'b0);

      // reset in the middle of ADD abandons the operation
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      data_in = 8'd100;
      @(posedge clk);
      #1;
      data_in = 8'd50;
      repeat (10) @(posedge clk);
      #1;
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_product", 32'(product), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      run_op("after_rst", 21, 6, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mul_repeated_add.md
Name: mul_repeated_add

Overview:
Unsigned integer multiplier that computes P = A × B by repeated addition.
- The controller FSM and the datapath live in one block: operand registers A and B, an accumulator P, a down-counter on B, and a zero detector.
- Both operands arrive one after the other on a shared input bus, after a start request.
- Used as a small, area-cheap, multi-cycle multiplier where latency is not critical.

Parameters:
WIDTH, 8, operand width in bits; the product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset; synchronous, active-low.
start  input  1  request to begin a multiplication; sampled in IDLE only.
data_in  input  WIDTH  shared operand bus; carries A, then B, on consecutive cycles.
product  output  2*WIDTH  accumulator P; holds the final result while done=1.
done  output  1  result valid; registered.
busy  output  1  high in LOAD_A, LOAD_B and ADD.

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, A=0, B=0, P=0, done=0, busy=0.
  - Reset has priority over every other event, including mid-operation; the operation is abandoned.
- States:
  - IDLE: done=0. If start=1, go to LOAD_A. Otherwise stay.
  - LOAD_A: A <= data_in. Go to LOAD_B.
  - LOAD_B: B <= data_in, P <= 0 (clearP). Go to ADD.
  - ADD: if B != 0, then P <= P + zero-extended A and B <= B - 1, and stay in ADD. If B == 0 (eqz), go to DONE with no add.
  - DONE: done=1 and P is frozen. Stay while start=1; return to IDLE once start=0.
- Handshake:
  - The source must drive A on data_in during the cycle after start is sampled, and B during the cycle after that.
  - data_in is ignored in every other state.
  - start is ignored outside IDLE and DONE; a held start does not retrigger until it has been seen low in DONE.
- Latency: done rises at the (B+4)th rising edge after the edge that sampled start.
  - B=0 gives done after 4 edges with product=0.
  - A=0 iterates B times, adding zero.
- Arithmetic: unsigned. The accumulator is 2*WIDTH bits, so the maximum (2^WIDTH-1)^2 never overflows. The B decrement never wraps, because it is gated by B != 0.
- product is visible during ADD as a partial sum. It is only guaranteed correct while done=1.
- busy = (state is LOAD_A, LOAD_B or ADD).
- Illegal or unused state encodings return to IDLE on the next edge.

Optional Feature:
Macro MUL_SWAP_EN.
- Defined: in the first ADD cycle (one extra cycle, no add in it), if B > A, A and B are swapped, so the counter always holds min(A,B).
  - The product is unchanged.
  - Latency becomes min(A,B)+5 edges when B > A, otherwise B+4.
- Not defined: no swap; latency is always B+4; there is no extra cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 edges during an active ADD -> state IDLE, product=0, done=0, busy=0; a new start then works normally.
- Basic: start=1, A=255, B=200 (WIDTH=8) -> product=51000, done high at edge 204 after start is sampled; busy low once done.
- Zero cases:
  - A=7, B=0 -> product=0, done after 4 edges.
  - A=0, B=9 -> product=0, done after 13 edges.
- Max: A=255, B=255 -> product=65025 (no overflow); B decrements to 0 and does not wrap.
- Handshake: hold start=1 through DONE -> done stays 1 and product is stable; drop start -> IDLE, done=0; toggle data_in during ADD -> no effect on result.
- MUL_SWAP_EN: A=3, B=250 -> product=750, done at edge 8; without the macro, done at edge 254.
